wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter with a registered output stage, sharing one downstream valid/ready port between N requesters.
- Sits where the plain round-robin arbiter sits, for paths that need bandwidth shares or burst locking.
- A winner holds the grant for up to its programmed weight of beats, then priority rotates to the next index.

---
 rtl/wrr_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_wrr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
//
// Weighted round-robin arbiter feeding one registered valid/ready output slot.
// N requesters compete for a single downstream port. A requester that wins
// keeps the grant for up to its programmed weight, after which priority
// rotates to the next index. A weight of 0 behaves as a weight of 1.
//
// Optional build macro:
//   WRR_LAST_EN - adds the i_last port. Weights then count whole packets
//                 rather than beats, and a packet is never interleaved with
//                 another requester's beats.
//
// Parameters:
//   N  - number of requesters (>= 2)
//   D  - data width per requester
//   WW - weight field width per requester
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     [N]      per-requester valid
//   o_ready     [N]      per-requester ready, at most one bit set
//   i_data      [N*D]    requester k data at [k*D +: D]
//   i_weight    [N*WW]   requester k weight at [k*WW +: WW], sampled at grant
//   i_last      [N]      (WRR_LAST_EN only) final beat of a packet
//   o_valid     downstream valid (registered)
//   i_ready     downstream ready
//   o_data      [D]      downstream data (registered)
//   o_grant_id  [log2N]  index of the requester whose beat is in o_data
// ---------------------------------------------------------------------------
module wrr_arbiter #(
  parameter int N  = 8,
  parameter int D  = 32,
  parameter int WW = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         o_ready,
  input  logic [N*D-1:0]       i_data,
  input  logic [N*WW-1:0]      i_weight,
`ifdef WRR_LAST_EN
  input  logic [N-1:0]         i_last,
`endif
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [D-1:0]         o_data,
  output logic [$clog2(N)-1:0] o_grant_id
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [WW-1:0]   beats_q, beats_d;

  logic            slot_free;
  logic            found;
  logic [IW-1:0]   search_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   cand_next;
  logic            cand_ok;
  logic            xfer;
  logic [WW-1:0]   w_raw;
  logic [WW-1:0]   w_eff;
`ifdef WRR_LAST_EN
  logic            cand_last;
`endif

  // The slot can accept a new beat when it is empty or being drained.
  assign slot_free = !o_valid || i_ready;

  // Rotating priority search starting at ptr. The loop runs from the far end
  // back towards ptr so the last hit written is the one closest to ptr.
  always_comb begin : search
    int            k;
    logic [IW-1:0] kidx;
    found      = 1'b0;
    search_idx = '0;
    k          = 0;
    kidx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      kidx = IW'(k);
      if (i_valid[kidx]) begin
        found      = 1'b1;
        search_idx = kidx;
      end
    end
  end

  // While locked the candidate is pinned to the holder. A locked holder
  // that has dropped valid gets nothing, and nobody else is granted in that
  // cycle, so the release happens cleanly before the next search.
  assign cand      = (state_q == LOCKED) ? gnt_q : search_idx;
  assign cand_ok   = (state_q == LOCKED) || found;
  assign cand_next = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);

  // Ready is also held low while reset is asserted so that no beat is
  // advertised to requesters during reset.
  assign xfer = i_rst_n && cand_ok && i_valid[cand] && slot_free;

  always_comb begin
    o_ready       = '0;
    o_ready[cand] = xfer;
  end

  assign w_raw = i_weight[int'(cand)*WW +: WW];
  assign w_eff = (w_raw == '0) ? WW'(1) : w_raw;

`ifdef WRR_LAST_EN
  assign cand_last = i_last[cand];
`endif

  // Lock control. Everything holds while the slot is blocked, so downstream
  // backpressure alone can never end a lock or move the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    beats_d = beats_q;
    if (slot_free) begin
      case (state_q)
        UNLOCKED: begin
          if (xfer) begin
`ifdef WRR_LAST_EN
            // A packet in progress must stay with its owner, so a non-final
            // beat always locks and the current packet counts towards w.
            if (!cand_last) begin
              state_d = LOCKED;
              gnt_d   = cand;
              beats_d = w_eff;
            end else if (w_eff == WW'(1)) begin
              ptr_d = cand_next;
            end else begin
              state_d = LOCKED;
              gnt_d   = cand;
              beats_d = w_eff - WW'(1);
            end
`else
            if (w_eff == WW'(1)) begin
              ptr_d = cand_next;
            end else begin
              state_d = LOCKED;
              gnt_d   = cand;
              beats_d = w_eff - WW'(1);
            end
`endif
          end
        end
        LOCKED: begin
          if (!i_valid[gnt_q]) begin
            // Holder went idle: forfeit whatever share is left.
            state_d = UNLOCKED;
            ptr_d   = cand_next;
            beats_d = '0;
          end else if (xfer) begin
`ifdef WRR_LAST_EN
            if (cand_last) begin
              if (beats_q == WW'(1)) begin
                state_d = UNLOCKED;
                ptr_d   = cand_next;
                beats_d = '0;
              end else begin
                beats_d = beats_q - WW'(1);
              end
            end
`else
            if (beats_q == WW'(1)) begin
              state_d = UNLOCKED;
              ptr_d   = cand_next;
              beats_d = '0;
            end else begin
              beats_d = beats_q - WW'(1);
            end
`endif
          end
        end
        default: begin
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  // Arbitration state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= UNLOCKED;
      ptr_q   <= '0;
      gnt_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      beats_q <= beats_d;
    end
  end

  // Single output register stage. A new beat overwrites the slot whenever
  // it is accepted; otherwise the slot empties once downstream takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_grant_id <= '0;
    end else if (xfer) begin
      o_valid    <= 1'b1;
      o_data     <= i_data[int'(cand)*D +: D];
      o_grant_id <= cand;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_arbiter
//
// Self-checking bench for wrr_arbiter. Each directed phase queues the grant
// sequence it expects; a monitor on the falling clock edge compares every
// presented output beat against the head of that queue and pops it when
// downstream accepts it. Each phase starts from reset so that expected
// sequences can be derived by hand from a known pointer position.
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;

  localparam int N  = 8;
  localparam int D  = 32;
  localparam int WW = 4;
  localparam int IW = 3;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [N-1:0]      i_valid;
  logic [N-1:0]      o_ready;
  logic [N*D-1:0]    i_data;
  logic [N*WW-1:0]   i_weight;
`ifdef WRR_LAST_EN
  logic [N-1:0]      i_last;
`endif
  logic              o_valid;
  logic              i_ready;
  logic [D-1:0]      o_data;
  logic [IW-1:0]     o_grant_id;

  typedef struct {
    logic [IW-1:0] id;
    logic [D-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   phase        = 0;

  wrr_arbiter #(.N(N), .D(D), .WW(WW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_weight   (i_weight),
`ifdef WRR_LAST_EN
    .i_last     (i_last),
`endif
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_grant_id (o_grant_id)
  );

  always #5 i_clk = ~i_clk;

  // Data word carries the phase and requester index so a beat from the
  // wrong requester or a stale phase is recognisable.
  function automatic logic [D-1:0] data_of(int ph, int k);
    return {8'hA5, 8'(ph), 8'h00, 8'(k)};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic setData();
    for (int k = 0; k < N; k++) i_data[k*D +: D] = data_of(phase, k);
  endtask

  task automatic pushExp(int k);
    exp_t e;
    e.id   = IW'(k);
    e.data = data_of(phase, k);
    exp_q.push_back(e);
  endtask

  // Queue a grant sequence written as a string of requester digits.
  task automatic pushIds(string s);
    for (int i = 0; i < s.len(); i++) pushExp(int'(s[i]) - 48);
  endtask

  task automatic applyStimulus(logic [N-1:0] v, int ncyc);
    i_valid = v;
    repeat (ncyc) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic startPhase(int ph, logic [N*WW-1:0] w);
    i_valid = '0;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(posedge i_clk);
    #1;
    phase    = ph;
    setData();
    i_weight = w;
    i_ready  = 1'b1;
`ifdef WRR_LAST_EN
    i_last   = '1;
`endif
    i_rst_n  = 1'b1;
  endtask

  task automatic finishPhase(string name);
    i_valid = '0;
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    checkOutput({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: ready legality every cycle, and every presented beat compared
  // against the scoreboard head (held beats stay at the head until taken).
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      checkOutput("ready_onehot", 64'($onehot0(o_ready)), 64'd1);
      checkOutput("ready_without_valid", 64'(o_ready & ~i_valid), 64'd0);
      if (o_valid && !i_ready) checkOutput("ready_while_stalled", 64'(o_ready), 64'd0);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(o_grant_id), 64'hFF);
        end else begin
          checkOutput("grant_id", 64'(o_grant_id), 64'(exp_q[0].id));
          checkOutput("data", 64'(o_data), 64'(exp_q[0].data));
          if (i_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = '1;
    i_ready  = 1'b1;
    i_weight = 32'h1111_1111;
`ifdef WRR_LAST_EN
    i_last   = '1;
`endif
    phase    = 0;
    setData();

    // Reset held with every requester asking.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("reset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_o_ready", 64'(o_ready), 64'd0);
    checkOutput("reset_o_data", 64'(o_data), 64'd0);
    checkOutput("reset_o_grant_id", 64'(o_grant_id), 64'd0);

    // First grant after reset goes to 0, then equal share over 0..3.
    @(posedge i_clk);
    #1;
    phase = 1;
    setData();
    i_rst_n = 1'b1;
    pushIds("0");
    applyStimulus(8'hFF, 1);
    pushIds("12301230");
    applyStimulus(8'h0F, 8);
    finishPhase("equal_share");

    // Weight 3 on requester 0, weight 1 on requester 1.
    startPhase(2, 32'h1111_1113);
    pushIds("00010001");
    applyStimulus(8'h03, 8);
    finishPhase("weights");

    // Weight 0 behaves as 1.
    startPhase(3, 32'h1111_1100);
    pushIds("0101");
    applyStimulus(8'h03, 4);
    finishPhase("weight_zero");

    // Five stalled cycles with a beat held in the slot.
    startPhase(4, 32'h1111_1111);
    pushIds("0101");
    applyStimulus(8'h03, 1);
    i_ready = 1'b0;
    applyStimulus(8'h03, 5);
    i_ready = 1'b1;
    applyStimulus(8'h03, 3);
    finishPhase("backpressure");

    // Requester 2 locks with weight 4 and drops after two beats; one empty
    // cycle, then search resumes at 3, skipping the lower requester 1.
    startPhase(5, 32'h1111_1411);
    pushIds("22341");
    applyStimulus(8'h1C, 2);
    applyStimulus(8'h1A, 4);
    finishPhase("valid_drop");

    // Three-beat packet from 5 competing with 6.
    startPhase(6, 32'h1111_1111);
`ifdef WRR_LAST_EN
    pushIds("5556");
    i_last = 8'h40;
`else
    pushIds("5656");
`endif
    applyStimulus(8'h60, 2);
`ifdef WRR_LAST_EN
    i_last = 8'hE0;
`endif
    applyStimulus(8'h60, 2);
    finishPhase("packet");

    // Reset while a beat is held discards it at once; arbitration restarts at 0.
    startPhase(7, 32'h1111_1111);
    i_ready = 1'b0;
    pushIds("0");
    applyStimulus(8'h01, 2);
    checkOutput("held_before_reset", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("midreset_o_ready", 64'(o_ready), 64'd0);
    exp_q.delete();
    i_valid = '0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    pushIds("0");
    applyStimulus(8'hFF, 1);
    finishPhase("after_midreset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
